// File: rtl/uram_readout_requester.sv
// uram_readout_requester
//
// Queues readout start addresses from single-cycle triggers and hands them,
// one at a time, to a URAM readout engine over an AXI-Stream style address
// channel. An issue is allowed only while the number of readouts that have
// been handed over but not yet finished downstream is below MAX_OUTSTANDING.
// After each handshake the block waits for the engine's begin_i pulse and
// gives up after BEGIN_TIMEOUT cycles.
//
// Ports
//   memclk          sole clock
//   memclk_rst_i    synchronous active-high reset
//   trig_i          single-cycle readout request
//   trig_addr_i     readout start address, captured with trig_i
//   trig_full_o     request FIFO full (requests arriving now are dropped)
//   m_axis_tdata    address to the readout engine
//   m_axis_tvalid   address valid
//   m_axis_tready   engine accepts address
//   begin_i         engine started the accepted readout
//   done_i          downstream buffer finished one readout
//   outstanding_o   readouts issued and not yet done
//   drop_count_o    requests lost to a full FIFO, saturating
//   err_o           sticky protocol error
module uram_readout_requester #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int BEGIN_TIMEOUT   = 255
) (
  input  logic        memclk,
  input  logic        memclk_rst_i,
  input  logic        trig_i,
  input  logic [15:0] trig_addr_i,
  output logic        trig_full_o,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        begin_i,
  input  logic        done_i,
  output logic [1:0]  outstanding_o,
  output logic [15:0] drop_count_o,
  output logic        err_o
);

  localparam int DATA_W = 16;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PW     = AW + 1;
  localparam int TMO_W  = $clog2(BEGIN_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BEGIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BEGIN
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr_nxt;
  logic [PW-1:0]     rd_ptr_nxt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              full_nxt;
  logic              credit_ok;
  logic              hs;
  logic              done_ok;
  logic              done_err;
  logic              begin_err;

  always_comb begin
    // The push is gated by the registered full flag, so a pop on the same
    // edge as a push-while-full never rescues the new request.
    push       = trig_i && !trig_full_o;
    fifo_empty = (wr_ptr == rd_ptr);
    credit_ok  = (outstanding_o < 2'(MAX_OUTSTANDING));
    pop        = (state == IDLE) && !fifo_empty && credit_ok;
    hs         = (state == ISSUE) && m_axis_tready;
    done_ok    = done_i && (outstanding_o != 2'd0);
    done_err   = done_i && (outstanding_o == 2'd0);
    begin_err  = begin_i && (state != WAIT_BEGIN);
    wr_ptr_nxt = push ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_nxt = pop  ? rd_ptr + PW'(1) : rd_ptr;
    // Same index, different lap bit: writer is a full lap ahead.
    full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                 (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
  end

  // Storage only; occupancy lives in the pointers, so no reset is needed.
  always_ff @(posedge memclk) begin
    if (push && !memclk_rst_i) begin
      fifo_mem[wr_ptr[AW-1:0]] <= trig_addr_i;
    end
  end

  always_ff @(posedge memclk) begin
    if (memclk_rst_i) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      trig_full_o   <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      outstanding_o <= 2'd0;
      drop_count_o  <= 16'd0;
      err_o         <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      trig_full_o <= full_nxt;

      if (trig_i && trig_full_o) begin
        drop_count_o <= sat_inc16(drop_count_o);
      end

      // Credit bookkeeping: an issue and a completion on one edge cancel.
      case ({hs, done_ok})
        2'b10:   outstanding_o <= outstanding_o + 2'd1;
        2'b01:   outstanding_o <= outstanding_o - 2'd1;
        default: outstanding_o <= outstanding_o;
      endcase

      if (done_err || begin_err) begin
        err_o <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            m_axis_tdata  <= fifo_mem[rd_ptr[AW-1:0]];
            m_axis_tvalid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (hs) begin
            m_axis_tvalid <= 1'b0;
            tmo_cnt       <= '0;
            state         <= WAIT_BEGIN;
          end
        end
        WAIT_BEGIN: begin
          if (begin_i) begin
            state <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            err_o <= 1'b1;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
